// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types and constants for the MM:SS countdown timer.
// Holds the FSM state enum and the BCD legality helper.
package bcd_countdown_timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    EXPIRED
  } state_t;

  localparam logic [3:0] DIGIT_MAX_UNITS = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX    = 4'd5;

  function automatic logic bcd_ok(
    input logic [3:0] d,
    input logic [3:0] max
  );
    return d <= max;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_digit.sv
// One down-counting BCD digit with borrow in/out.
// Wraps 0 -> MAX only when a borrow reaches it.
module bcd_digit_down #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_en,
  input  logic [3:0] load_val,
  input  logic       dec_en,
  input  logic       borrow_in,
  output logic [3:0] digit,
  output logic       borrow_out
);

  logic [3:0] r_digit;
  logic       w_step;

  assign w_step     = dec_en & borrow_in;
  assign borrow_out = w_step & (r_digit == 4'd0);
  assign digit      = r_digit;

  // digit register: reset, load, or borrow-driven decrement
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_digit <= 4'd0;
    end else if (load_en) begin
      r_digit <= load_val;
    end else if (w_step) begin
      r_digit <= (r_digit == 4'd0) ? MAX : r_digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer with load check and done pulse.
// FSM here; the four digits form a borrow chain below.
module bcd_countdown_timer
  import bcd_countdown_timer_pkg::*;
#(
  parameter int MIN_TENS_MAX = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] load_min_tens,
  input  logic [3:0] load_min_units,
  input  logic [3:0] load_sec_tens,
  input  logic [3:0] load_sec_units,
  output logic [3:0] min_tens,
  output logic [3:0] min_units,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic       running,
  output logic       expired,
  output logic       done,
  output logic       load_err
);

  localparam logic [3:0] MT_MAX = 4'(MIN_TENS_MAX);

  state_t     r_state;
  state_t     w_next;
  logic       r_done;
  logic       r_load_err;
  logic       w_legal;
  logic       w_zero;
  logic       w_one;
  logic       w_dec;
  logic       w_load_acc;
  logic       w_load_rej;
  logic [4:0] w_b;

  assign w_legal = bcd_ok(load_sec_units, DIGIT_MAX_UNITS)
                 & bcd_ok(load_sec_tens, SEC_TENS_MAX)
                 & bcd_ok(load_min_units, DIGIT_MAX_UNITS)
                 & bcd_ok(load_min_tens, MT_MAX);

  assign w_zero = (min_tens == 4'd0) & (min_units == 4'd0)
                & (sec_tens == 4'd0) & (sec_units == 4'd0);
  assign w_one  = (min_tens == 4'd0) & (min_units == 4'd0)
                & (sec_tens == 4'd0) & (sec_units == 4'd1);

  // a rejected or accepted load, and stop, both suppress the tick
  assign w_dec = tick & ~load & ~stop & (r_state == RUN);

  assign w_b[0] = 1'b1;

  bcd_digit_down #(.MAX(DIGIT_MAX_UNITS)) u_su (
    .clk(clk), .reset(reset), .load_en(w_load_acc),
    .load_val(load_sec_units), .dec_en(w_dec),
    .borrow_in(w_b[0]), .digit(sec_units), .borrow_out(w_b[1])
  );

  bcd_digit_down #(.MAX(SEC_TENS_MAX)) u_st (
    .clk(clk), .reset(reset), .load_en(w_load_acc),
    .load_val(load_sec_tens), .dec_en(w_dec),
    .borrow_in(w_b[1]), .digit(sec_tens), .borrow_out(w_b[2])
  );

  bcd_digit_down #(.MAX(DIGIT_MAX_UNITS)) u_mu (
    .clk(clk), .reset(reset), .load_en(w_load_acc),
    .load_val(load_min_units), .dec_en(w_dec),
    .borrow_in(w_b[2]), .digit(min_units), .borrow_out(w_b[3])
  );

  bcd_digit_down #(.MAX(MT_MAX)) u_mt (
    .clk(clk), .reset(reset), .load_en(w_load_acc),
    .load_val(load_min_tens), .dec_en(w_dec),
    .borrow_in(w_b[3]), .digit(min_tens), .borrow_out(w_b[4])
  );

  // next state with priority load > stop > start > tick
  always_comb begin
    w_next     = r_state;
    w_load_acc = 1'b0;
    w_load_rej = 1'b0;
    if (load) begin
      if (r_state != RUN && w_legal) begin
        w_load_acc = 1'b1;
        w_next     = IDLE;
      end else begin
        w_load_rej = 1'b1;
      end
    end else if (stop) begin
      if (r_state == RUN) w_next = PAUSE;
    end else begin
      if (start && !w_zero &&
          (r_state == IDLE || r_state == PAUSE))
        w_next = RUN;
      // underflow out of the top digit cannot occur; treated as expiry
      if (w_dec && (w_one || w_b[4])) w_next = EXPIRED;
    end
  end

  // state and one-cycle pulse registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_done     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_done     <= w_dec & w_one;
      r_load_err <= w_load_rej;
    end
  end

  assign running  = (r_state == RUN);
  assign expired  = (r_state == EXPIRED);
  assign done     = r_done;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed plus random bench for the countdown timer.
// Reference keeps remaining time as a plain seconds count.
module tb_bcd_countdown_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       load = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] lmt = 4'd0;
  logic [3:0] lmu = 4'd0;
  logic [3:0] lst = 4'd0;
  logic [3:0] lsu = 4'd0;
  logic [3:0] min_tens, min_units, sec_tens, sec_units;
  logic       running, expired, done, load_err;

  bcd_countdown_timer #(.MIN_TENS_MAX(5)) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .load(load), .start(start), .stop(stop),
    .load_min_tens(lmt), .load_min_units(lmu),
    .load_sec_tens(lst), .load_sec_units(lsu),
    .min_tens(min_tens), .min_units(min_units),
    .sec_tens(sec_tens), .sec_units(sec_units),
    .running(running), .expired(expired),
    .done(done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_PAUSE = 2;
  localparam int M_EXP  = 3;

  int m_secs = 0;
  int m_st   = M_IDLE;
  bit m_done = 1'b0;
  bit m_lerr = 1'b0;
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int mins, secs;
    bit legal;
    m_done = 1'b0;
    m_lerr = 1'b0;
    if (!reset) begin
      m_secs = 0;
      m_st   = M_IDLE;
    end else if (load) begin
      legal = (lsu <= 9) && (lst <= 5) && (lmu <= 9) && (lmt <= 5);
      if (m_st != M_RUN && legal) begin
        mins   = int'(lmt) * 10 + int'(lmu);
        secs   = int'(lst) * 10 + int'(lsu);
        m_secs = mins * 60 + secs;
        m_st   = M_IDLE;
      end else begin
        m_lerr = 1'b1;
      end
    end else if (stop) begin
      if (m_st == M_RUN) m_st = M_PAUSE;
    end else if (start && (m_st == M_IDLE || m_st == M_PAUSE)) begin
      if (m_secs != 0) m_st = M_RUN;
    end else if (tick && m_st == M_RUN) begin
      m_secs--;
      if (m_secs == 0) begin
        m_st   = M_EXP;
        m_done = 1'b1;
      end
    end
  endtask

  task automatic check_all(string tag);
    int mins, secs;
    mins = m_secs / 60;
    secs = m_secs % 60;
    chk({tag, ":min_tens"}, 8'(min_tens), 8'(mins / 10));
    chk({tag, ":min_units"}, 8'(min_units), 8'(mins % 10));
    chk({tag, ":sec_tens"}, 8'(sec_tens), 8'(secs / 10));
    chk({tag, ":sec_units"}, 8'(sec_units), 8'(secs % 10));
    chk({tag, ":running"}, 8'(running), 8'(m_st == M_RUN));
    chk({tag, ":expired"}, 8'(expired), 8'(m_st == M_EXP));
    chk({tag, ":done"}, 8'(done), 8'(m_done));
    chk({tag, ":load_err"}, 8'(load_err), 8'(m_lerr));
  endtask

  task automatic step(string tag, bit rst, bit ld,
                      int mt, int mu, int st, int su,
                      bit sta, bit stp, bit tk);
    reset = ~rst;
    load  = ld;
    lmt   = 4'(mt);
    lmu   = 4'(mu);
    lst   = 4'(st);
    lsu   = 4'(su);
    start = sta;
    stop  = stp;
    tick  = tk;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    reset = 1'b1;
    load  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    tick  = 1'b0;
  endtask

  task automatic ld(string tag, int mt, int mu, int st, int su);
    step(tag, 0, 1, mt, mu, st, su, 0, 0, 0);
  endtask

  task automatic go(string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic halt(string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic tk(string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic nop(string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    step("rst_init", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rst_init", 1, 0, 0, 0, 0, 0, 0, 0, 0);

    ld("ld_0327", 0, 3, 2, 7);
    go("go_0327");
    tk("tk_0327");
    step("rst_run", 1, 0, 0, 0, 0, 0, 0, 0, 1);
    step("rst_run", 1, 0, 0, 0, 0, 0, 1, 0, 1);
    nop("post_rst");

    ld("ld_1000", 1, 0, 0, 0);
    go("go_1000");
    tk("borrow_0959");
    tk("dec_0958");
    halt("halt_0958");
    ld("ld_0100", 0, 1, 0, 0);
    go("go_0100");
    tk("borrow_0059");

    halt("halt_0059");
    ld("ld_0002", 0, 0, 0, 2);
    go("go_0002");
    tk("tk_0001");
    tk("expire");
    nop("done_clear");
    for (int i = 0; i < 3; i++) tk("tick_expired");

    ld("ld_0500", 0, 5, 0, 0);
    go("go_0500");
    step("tick_stop", 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step("start_tick", 0, 0, 0, 0, 0, 0, 1, 0, 1);
    tk("dec_0459");

    halt("halt_0459");
    ld("ld_bad", 0, 0, 6, 10);
    nop("lerr_clear");
    go("go_0459");
    ld("ld_in_run", 0, 2, 0, 0);
    tk("run_after_lerr");
    tk("run_after_lerr");

    halt("halt2");
    ld("ld_0000", 0, 0, 0, 0);
    go("start_zero");
    nop("zero_idle");
    ld("ld_0001", 0, 0, 0, 1);
    go("go_0001");
    tk("expire2");
    go("start_expired");
    ld("ld_0030", 0, 0, 3, 0);
    step("stop_start_idle", 0, 0, 0, 0, 0, 0, 1, 1, 0);

    for (int i = 0; i < 800; i++) begin
      bit r_rst, r_ld, r_sta, r_stp, r_tk;
      int mt, mu, st, su;
      r_rst = ($urandom_range(0, 63) == 0);
      r_ld  = ($urandom_range(0, 15) == 0);
      r_stp = ($urandom_range(0, 15) == 0);
      r_sta = ($urandom_range(0, 7) == 0);
      r_tk  = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) begin
        mt = $urandom_range(0, 15);
        mu = $urandom_range(0, 15);
        st = $urandom_range(0, 15);
        su = $urandom_range(0, 15);
      end else begin
        mt = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 5) : 0;
        mu = $urandom_range(0, 1);
        st = $urandom_range(0, 5);
        su = $urandom_range(0, 9);
      end
      step("rand", r_rst, r_ld, mt, mu, st, su, r_sta, r_stp, r_tk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
MM:SS countdown timer built from four BCD digits, counting down where the clock's bcd_counter counts up.
- Loaded with a start time, it decrements once per 1 Hz tick while running, then raises a one-cycle done pulse and a sticky expired flag at 00:00.
- Sits beside the clock's seconds/minutes counters and shares their 1 Hz tick.
- Its BCD outputs feed the same 7-segment display path.

Parameters:
MIN_TENS_MAX, 5, largest legal minutes-tens digit (5 gives a 59:59 ceiling; 9 gives 99:59).

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-low reset; sampled on rising clk.
tick  input  1  one-cycle 1 Hz enable pulse.
load  input  1  request to capture load_* digits.
start  input  1  request to run.
stop  input  1  request to pause.
load_min_tens  input  4  BCD value to load.
load_min_units  input  4  BCD value to load.
load_sec_tens  input  4  BCD value to load.
load_sec_units  input  4  BCD value to load.
min_tens  output  4  current BCD digit.
min_units  output  4  current BCD digit.
sec_tens  output  4  current BCD digit.
sec_units  output  4  current BCD digit.
running  output  1  high while state is RUN.
expired  output  1  high while state is EXPIRED.
done  output  1  one-cycle pulse on reaching 00:00.
load_err  output  1  one-cycle pulse when a load is rejected.

Behaviour:
Reset:
- reset==0 at a rising edge forces all digits to 0, state IDLE, and running/expired/done/load_err to 0.
- Reset wins over every other input, including mid-RUN.

States:
- IDLE, RUN, PAUSE, EXPIRED.
- running = (state==RUN); expired = (state==EXPIRED). Both are registered and decoded from state.

Priority within a cycle: load > stop > start > tick.

Load:
- Accepted in IDLE, PAUSE or EXPIRED when every digit is legal:
  - sec_units <= 9
  - sec_tens <= 5
  - min_units <= 9
  - min_tens <= MIN_TENS_MAX
- Accepted load: digits update on that edge; next state is IDLE.
- Load in RUN, or with any illegal digit: digits and state are unchanged, and load_err=1 for exactly the next cycle.

Start:
- IDLE or PAUSE with value != 00:00 moves to RUN.
- Start with value 00:00, or start in EXPIRED, is ignored. No done pulse.

Stop:
- RUN moves to PAUSE.
- Stop in any other state is ignored.
- Stop together with start: stop wins.

Decrement:
- Occurs only when tick=1, state==RUN and stop=0. At most one decrement per tick.
- Borrow chain, one edge, no intermediate states visible:
  - sec_units 0 -> 9 with borrow, otherwise minus 1.
  - sec_tens 0 -> 5 with borrow, otherwise minus 1; changes only on borrow.
  - min_units 0 -> 9 with borrow, otherwise minus 1; changes only on borrow.
  - min_tens minus 1; changes only on borrow.
- Examples: 10:00 -> 09:59; 01:00 -> 00:59.

Expiry:
- The decrement edge that produces 00:00 also moves state to EXPIRED.
- done=1 in the cycle immediately after that edge, for exactly one cycle.
- expired stays high until an accepted load.
- Digits hold 00:00 in EXPIRED; further ticks have no effect.

Other rules:
- Tick in IDLE, PAUSE or EXPIRED: no change.
- Tick in the same cycle as the start that enters RUN: no decrement; counting begins on the next tick.
- Digits are always legal BCD; no wrap above the loaded value is possible.

Decomposition:
Shared package:
- state enum: IDLE, RUN, PAUSE, EXPIRED.
- constants: DIGIT_MAX_UNITS=9, SEC_TENS_MAX=5.
- a BCD-legal check function.

Sub-module bcd_digit_down (parameter MAX):
- inputs: dec_en, borrow_in.
- outputs: digit, borrow_out, where borrow_out = dec_en & borrow_in & (digit==0).
- Instantiated 4 times in a chain: sec_units, sec_tens, min_units, min_tens.

The top level holds the FSM, the load check and the done/load_err pulse registers.

Test Plan:
1. Reset: drive reset=0 for 2 cycles mid-RUN at 03:27 -> all digits 0, state IDLE, running=expired=done=load_err=0.
2. Borrow chain:
   - load 10:00, start, 1 tick -> 09:59.
   - 1 more tick -> 09:58.
   - load 01:00, start, 1 tick -> 00:59.
3. Expiry:
   - load 00:02, start, 2 ticks -> 00:00, expired=1.
   - done high exactly 1 cycle after the second tick edge.
   - 3 further ticks -> still 00:00, done=0.
4. Pause/priority:
   - RUN at 05:00; tick+stop same cycle -> stays 05:00, state PAUSE.
   - start+tick same cycle -> RUN, still 05:00; next tick -> 04:59.
5. Load rejection:
   - load 00:6A (sec_tens=6) -> digits unchanged, load_err=1 for one cycle.
   - load 02:00 while RUN -> load_err=1, counting continues.
6. Zero start / expired clear:
   - start at 00:00 in IDLE -> stays IDLE, done=0.
   - in EXPIRED, load 00:30 -> IDLE, expired=0, digits 00:30.
